reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Integer register file and pending-write scoreboard for the rvcore pipeline.
- Sinks the writeback stream (wb_en, rd, result) and serves the two decode-stage source reads with same-cycle write bypass.
- Tracks which architectural registers have an in-flight writer and raises a hazard when decode reads a register that is still pending, or redefines one.
- Sits between decode/issue (read and issue side) and writeback (write side).

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; x0 is hardwired zero.
- ADDR_W, 5, register index width; must equal $clog2(NUM_REGS).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_en  in  1  writeback strobe from write stage.
- wb_rd  in  ADDR_W  destination index of writeback.
- wb_data  in  XLEN  value to write.
- rs1_addr  in  ADDR_W  decode source 1 index.
- rs2_addr  in  ADDR_W  decode source 2 index.
- rs1_data  out  XLEN  source 1 value (combinational).
- rs2_data  out  XLEN  source 2 value (combinational).
- issue_valid  in  1  decode attempts to issue the instruction this cycle.
- issue_wb  in  1  issuing instruction will write a register.
- issue_rd  in  ADDR_W  destination of the issuing instruction.
- issue_ready  out  1  1 = no hazard; the issue is accepted when issue_valid && issue_ready.
- busy_vec  out  NUM_REGS  per-register pending-write bits, for debug and verification.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: all registers clear to 0 and busy_vec clears to 0, on the edge where rst=1. rst overrides every write and issue in that cycle.
- With rst held, rs*_data read 0 and issue_ready=1 combinationally.
- Write port:
  - On the edge with wb_en=1 and wb_rd!=0, regs[wb_rd] <= wb_data.
  - Writes to x0 are dropped.
  - wb_en=1 also clears busy[wb_rd], unless the set rule below applies.
- Read ports, combinational:
  - addr==0 returns 0.
  - Else, if wb_en && wb_rd==addr, return wb_data (bypass, same-cycle visibility).
  - Else return regs[addr].
  - Both ports are independent and may read the same address.
- Hazard / issue_ready:
  - A register's effective busy = busy[r] && !(wb_en && wb_rd==r). A same-cycle writeback resolves the hazard because of the bypass.
  - raw1 = effective busy of rs1_addr; raw2 = effective busy of rs2_addr.
  - waw = issue_wb && effective busy of issue_rd.
  - issue_ready = !(raw1 || raw2 || waw). x0 is never busy.
  - issue_ready is a function of current inputs and state only; it does not depend on issue_valid.
- Scoreboard set:
  - On the edge with issue_valid && issue_ready && issue_wb && issue_rd!=0, busy[issue_rd] <= 1.
  - When set and clear target the same register in one cycle, set wins (the new writer is pending).
- At most one outstanding writer per register, guaranteed by the waw stall.
- A stalled issue (issue_ready=0) changes no state. Decode holds its inputs until ready.
- wb_en to a non-busy register is legal: data is written and busy stays 0.
- Latency:
  - Write is visible through the bypass in the same cycle, and from the array in the next cycle.
  - The busy set is visible from the next cycle.
- Reset mid-operation: all pending busy bits are discarded. The pipeline flush is the upstream owner's responsibility.

Test Plan:
- Reset then read: assert rst 1 cycle, read rs1=5, rs2=31 -> both 0, issue_ready=1, busy_vec=0.
- Write/read and bypass:
  - wb_en=1, wb_rd=3, wb_data=32'h1234_5678 with rs1_addr=3 in the same cycle -> rs1_data=32'h12345678.
  - Next cycle with wb_en=0 -> still 32'h12345678.
- x0 protection: wb_en=1, wb_rd=0, wb_data=32'hdeadbeef, then read rs1=0 -> 0. Issue with issue_rd=0 -> busy_vec stays 0.
- RAW stall and release:
  - Issue with issue_wb=1, issue_rd=7 -> busy_vec[7]=1.
  - Next instruction with rs2_addr=7 -> issue_ready=0.
  - Cycle with wb_en=1, wb_rd=7, wb_data=42 -> issue_ready=1, rs2_data=42. busy_vec[7]=0 afterwards.
- WAW and simultaneous set/clear:
  - busy[9]=1; issue with issue_rd=9 -> issue_ready=0.
  - Same cycle as wb_en for rd 9 -> issue_ready=1, accepted. busy_vec[9]=1 after the edge (set wins).
- Reset mid-flight: busy[4]=1, busy[10]=1, regs nonzero; pulse rst with wb_en=1 -> busy_vec=0, all reads 0, write ignored.

Source files
------------

// File: rtl/reg_file.sv
// Integer register file with pending-write scoreboard.
// Two combinational read ports with same-cycle writeback bypass, one write
// port, and per-register busy tracking that stalls RAW/WAW hazards at issue.
module reg_file #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  input  logic                issue_valid,
  input  logic                issue_wb,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] eff_busy;
  logic                wr_live;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic                issue_fire;

  // A writeback to x0 neither stores data nor counts as a bypass source.
  assign wr_live = wb_en && (wb_rd != '0);

  // One-hot of the register being written back this cycle.
  always_comb begin
    wb_mask = '0;
    if (wb_en) begin
      wb_mask[wb_rd] = 1'b1;
    end
  end

  // A same-cycle writeback resolves the hazard since the bypass supplies the value.
  assign eff_busy = busy_q & ~wb_mask;

  // Source port 1: zero for x0 or during reset, else bypass, else array.
  always_comb begin
    rs1_data = '0;
    if (!rst && (rs1_addr != '0)) begin
      if (wr_live && (wb_rd == rs1_addr)) begin
        rs1_data = wb_data;
      end else begin
        rs1_data = regs_q[rs1_addr];
      end
    end
  end

  // Source port 2: identical to port 1, fully independent.
  always_comb begin
    rs2_data = '0;
    if (!rst && (rs2_addr != '0)) begin
      if (wr_live && (wb_rd == rs2_addr)) begin
        rs2_data = wb_data;
      end else begin
        rs2_data = regs_q[rs2_addr];
      end
    end
  end

  // Hazard detection; x0 never has its busy bit set so it never stalls.
  always_comb begin
    raw1        = eff_busy[rs1_addr];
    raw2        = eff_busy[rs2_addr];
    waw         = issue_wb && eff_busy[issue_rd];
    issue_ready = rst || !(raw1 || raw2 || waw);
  end

  assign issue_fire = issue_valid && issue_ready;

  // Scoreboard next state: writeback clears first so a same-register issue set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_fire && issue_wb && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  // Scoreboard register; reset discards every pending writer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register array; reset clears all entries and overrides the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                wb_en;
  logic [ADDR_W-1:0]   wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic [ADDR_W-1:0]   rs1_addr;
  logic [ADDR_W-1:0]   rs2_addr;
  logic [XLEN-1:0]     rs1_data;
  logic [XLEN-1:0]     rs2_data;
  logic                issue_valid;
  logic                issue_wb;
  logic [ADDR_W-1:0]   issue_rd;
  logic                issue_ready;
  logic [NUM_REGS-1:0] busy_vec;

  int errors = 0;
  int checks = 0;

  reg_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_wb(issue_wb), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Drive a full input vector at the falling edge, then settle.
  task automatic drive(input logic r, input logic we, input logic [ADDR_W-1:0] wrd,
                       input logic [XLEN-1:0] wd, input logic [ADDR_W-1:0] a1,
                       input logic [ADDR_W-1:0] a2, input logic iv, input logic iw,
                       input logic [ADDR_W-1:0] ird);
    @(negedge clk);
    rst = r; wb_en = we; wb_rd = wrd; wb_data = wd;
    rs1_addr = a1; rs2_addr = a2;
    issue_valid = iv; issue_wb = iw; issue_rd = ird;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd31, 1'b0, 1'b0, 5'd0);
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_rs1 got=%h exp=%h", rs1_data, 32'h0); end
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL reset_rs2 got=%h exp=%h", rs2_data, 32'h0); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd31, 1'b0, 1'b0, 5'd0);
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); end
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_array got=%h exp=%h", rs1_data, 32'h0); end
  endtask

  task automatic test_write_bypass();
    drive(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd3, 1'b0, 1'b0, 5'd0);
    checks++; if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_rs1 got=%h exp=%h", rs1_data, 32'h1234_5678); end
    checks++; if (rs2_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_rs2 got=%h exp=%h", rs2_data, 32'h1234_5678); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL nonbusy_wb_busy got=%h exp=%h", busy_vec, 32'h0); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0);
    checks++; if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL array_rs1 got=%h exp=%h", rs1_data, 32'h1234_5678); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL nonbusy_after got=%h exp=%h", busy_vec, 32'h0); end
    // Bypass must not apply when the write targets another register.
    drive(1'b0, 1'b1, 5'd4, 32'hAAAA_0004, 5'd3, 5'd5, 1'b0, 1'b0, 5'd0);
    checks++; if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_other got=%h exp=%h", rs1_data, 32'h1234_5678); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd4, 5'd3, 1'b0, 1'b0, 5'd0);
    checks++; if (rs1_data !== 32'hAAAA_0004) begin errors++; $display("FAIL array_r4 got=%h exp=%h", rs1_data, 32'hAAAA_0004); end
  endtask

  task automatic test_x0();
    drive(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=%h", rs1_data, 32'h0); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_read got=%h exp=%h", rs1_data, 32'h0); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready got=%b exp=1", issue_ready); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL x0_busy got=%h exp=%h", busy_vec, 32'h0); end
  endtask

  task automatic test_raw();
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_issue_ready got=%b exp=1", issue_ready); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd1, 5'd7, 1'b1, 1'b0, 5'd0);
    checks++; if (busy_vec !== 32'h0000_0080) begin errors++; $display("FAIL raw_busy_set got=%h exp=%h", busy_vec, 32'h0000_0080); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw2_stall got=%b exp=0", issue_ready); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd1, 1'b1, 1'b0, 5'd0);
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw1_stall got=%b exp=0", issue_ready); end
    checks++; if (busy_vec !== 32'h0000_0080) begin errors++; $display("FAIL raw_stall_hold got=%h exp=%h", busy_vec, 32'h0000_0080); end
    drive(1'b0, 1'b1, 5'd7, 32'd42, 5'd1, 5'd7, 1'b1, 1'b0, 5'd0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_release got=%b exp=1", issue_ready); end
    checks++; if (rs2_data !== 32'd42) begin errors++; $display("FAIL raw_bypass got=%h exp=%h", rs2_data, 32'd42); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd7, 1'b0, 1'b0, 5'd0);
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL raw_busy_clr got=%h exp=%h", busy_vec, 32'h0); end
    checks++; if (rs2_data !== 32'd42) begin errors++; $display("FAIL raw_array got=%h exp=%h", rs2_data, 32'd42); end
  endtask

  task automatic test_waw();
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL waw_busy_set got=%h exp=%h", busy_vec, 32'h0000_0200); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got=%b exp=0", issue_ready); end
    // Same register without a write destination is not a hazard.
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_nowb got=%b exp=1", issue_ready); end
    drive(1'b0, 1'b1, 5'd9, 32'd5, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_release got=%b exp=1", issue_ready); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL waw_set_wins got=%h exp=%h", busy_vec, 32'h0000_0200); end
    checks++; if (rs1_data !== 32'd5) begin errors++; $display("FAIL waw_data got=%h exp=%h", rs1_data, 32'd5); end
    drive(1'b0, 1'b1, 5'd9, 32'd6, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, '0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL waw_busy_clr got=%h exp=%h", busy_vec, 32'h0); end
    checks++; if (rs1_data !== 32'd6) begin errors++; $display("FAIL waw_data2 got=%h exp=%h", rs1_data, 32'd6); end
  endtask

  task automatic test_reset_midflight();
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4);
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10);
    drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd4, 1'b0, 1'b0, 5'd0);
    checks++; if (busy_vec !== 32'h0000_0410) begin errors++; $display("FAIL mid_busy got=%h exp=%h", busy_vec, 32'h0000_0410); end
    checks++; if (rs1_data !== 32'h1234_5678) begin errors++; $display("FAIL mid_pre_read got=%h exp=%h", rs1_data, 32'h1234_5678); end
    drive(1'b1, 1'b1, 5'd12, 32'h0000_00FF, 5'd3, 5'd12, 1'b1, 1'b1, 5'd11);
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL mid_rst_rs1 got=%h exp=%h", rs1_data, 32'h0); end
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL mid_rst_rs2 got=%h exp=%h", rs2_data, 32'h0); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd12, 1'b0, 1'b0, 5'd0);
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL mid_busy_clr got=%h exp=%h", busy_vec, 32'h0); end
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL mid_r3 got=%h exp=%h", rs1_data, 32'h0); end
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL mid_wr_ignored got=%h exp=%h", rs2_data, 32'h0); end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd4, 5'd10, 1'b0, 1'b0, 5'd0);
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL mid_r4 got=%h exp=%h", rs1_data, 32'h0); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", issue_ready); end
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    issue_valid = 1'b0; issue_wb = 1'b0; issue_rd = '0;
    test_reset();
    test_write_bypass();
    test_x0();
    test_raw();
    test_waw();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
